lfsr_seq_checker: RTL

//  Downstream consumer of the 4-bit x^4+x+1 LFSR pattern generator.
//  - Samples the generator state stream and self-synchronises to it.
//  - Predicts each next state and counts mismatches.
//  - Flags loss of sync.

---
 rtl/lfsr_seq_checker.sv | 123 ++++++++++++
 1 files changed

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 4-bit x^4+x+1 LFSR pattern stream.
// Locks onto the sequence, then free-runs its prediction and counts mismatches.
module lfsr_seq_checker #(
   parameter int unsigned LOCK_CNT    = 3,
   parameter int unsigned UNLOCK_ERRS = 4,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_vld,
   input  logic [3:0]           din,
   input  logic                 clr,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 err_sat
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LC = 4'(LOCK_CNT);
   localparam logic [3:0] UE = 4'(UNLOCK_ERRS);

   function automatic logic [3:0] f_nxt(input logic [3:0] s);
      return {s[0] ^ s[1], s[3], s[2], s[1]};
   endfunction

   state_t               r_state, w_state_nxt;
   logic [3:0]           r_exp, w_exp_nxt;
   logic [3:0]           r_match_cnt, w_match_nxt;
   logic [3:0]           r_bad_run, w_bad_nxt;
   logic                 r_locked, r_err, r_err_sat;
   logic [ERR_CNT_W-1:0] r_err_cnt, w_cnt_nxt;
   logic                 w_err_nxt, w_inc;

   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      w_match_nxt = r_match_cnt;
      w_bad_nxt   = r_bad_run;
      w_err_nxt   = 1'b0;
      w_inc       = 1'b0;
      if (din_vld) begin
         case (r_state)
            S_HUNT: begin
               // all-zero is the LFSR lock-up state and must never seed
               if (din != 4'h0) begin
                  w_exp_nxt   = f_nxt(din);
                  w_match_nxt = '0;
                  w_state_nxt = S_VERIFY;
               end
            end
            S_VERIFY: begin
               if (din == r_exp) begin
                  w_match_nxt = r_match_cnt + 4'd1;
                  w_exp_nxt   = f_nxt(din);
                  if (r_match_cnt + 4'd1 == LC) w_state_nxt = S_LOCKED;
               end else if (din != 4'h0) begin
                  w_exp_nxt   = f_nxt(din);
                  w_match_nxt = '0;
               end else begin
                  w_state_nxt = S_HUNT;
               end
            end
            S_LOCKED: begin
               // prediction free-runs so a corrupted sample cannot derail it
               w_exp_nxt = f_nxt(r_exp);
               if (din == r_exp) begin
                  w_bad_nxt = '0;
               end else begin
                  w_err_nxt = 1'b1;
                  w_inc     = 1'b1;
                  if (r_bad_run + 4'd1 == UE) begin
                     w_state_nxt = S_HUNT;
                     w_bad_nxt   = '0;
                  end else begin
                     w_bad_nxt = r_bad_run + 4'd1;
                  end
               end
            end
            default: w_state_nxt = S_HUNT;
         endcase
      end
   end

   always_comb begin
      w_cnt_nxt = r_err_cnt;
      if (clr)                          w_cnt_nxt = '0;
      else if (w_inc && r_err_cnt != '1) w_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_HUNT;
         r_exp       <= '0;
         r_match_cnt <= '0;
         r_bad_run   <= '0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
         r_err_sat   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_exp       <= w_exp_nxt;
         r_match_cnt <= w_match_nxt;
         r_bad_run   <= w_bad_nxt;
         r_locked    <= (w_state_nxt == S_LOCKED);
         r_err       <= w_err_nxt;
         r_err_cnt   <= w_cnt_nxt;
         r_err_sat   <= (w_cnt_nxt == '1);
      end
   end

   assign locked  = r_locked;
   assign err     = r_err;
   assign err_cnt = r_err_cnt;
   assign err_sat = r_err_sat;

endmodule
